w6link_host: RTL and testbench
==============================

Name: w6link_host

Overview:
- Host (initiator) end of the 6-wire w6 debug link whose device end sits behind the QSPI pins.
- Generates the link clock and direction, and moves bytes in both directions with CTS/RTS flow control.
- Exposes valid/ready byte streams to local logic. Used for FPGA-to-FPGA debug bridging and as the bench driver for the device end.

Parameters:
- CLK_DIV, 4: half-period of lk_clk in clk cycles. Legal values are ≥4, so the 2-flop sync delay fits inside the high phase.
- SYNC_STAGES, 2: synchronizer depth on lk_cts, lk_rts and lk_out.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send to the device
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; a byte is accepted when tx_valid&tx_ready
- rx_data  out  8  byte received from the device
- rx_valid  out  1  rx_data is valid; held until rx_ready
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  FSM not in IDLE
- lk_clk  out  1  link clock, idle low
- lk_dir  out  1  1 = host→device, 0 = device→host (idle 0)
- lk_cts  in  1  device can accept a byte (async)
- lk_rts  in  1  device has a byte for the host (async)
- lk_in  out  1  serial data host→device
- lk_out  in  1  serial data device→host (async)

Behaviour:
- Reset values: lk_clk=0, lk_dir=0, lk_in=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
- Reset mid-transfer aborts immediately: lk_clk drops low and the partial byte is discarded.
- Input sync: lk_cts, lk_rts and lk_out pass through SYNC_STAGES flops. The FSM uses only the synced values (cts_s, rts_s, out_s).
- Framing: 8 bits, MSB first. Data changes while lk_clk is low; the device samples on the rising edge.
- TX holding register (1 entry): loads on handshake, and tx_ready falls the next cycle. tx_ready returns to 1 in the cycle TX_SHIFT finishes its 8th bit.
- FSM states: IDLE, TURN, TX_SHIFT, RX_SHIFT.
- IDLE, start conditions:
  - RX start: rts_s=1 and rx_valid=0.
  - TX start: tx pending and cts_s=1.
  - If both hold, RX wins (drain device first).
  - If rx_valid=1, RX is never started: this is the back-pressure, so overrun cannot occur.
- On start: set lk_dir (1 for TX, 0 for RX), then enter TURN for CLK_DIV cycles with lk_clk low.
  - For TX, lk_in is driven with bit7 on entry to TURN.
- Bit timing: each bit has a high phase of CLK_DIV cycles, then a low phase of CLK_DIV cycles. The bit counter runs 7 down to 0.
- TX_SHIFT:
  - At each high→low transition, lk_in advances to the next bit.
  - After bit0's low phase, go to IDLE; lk_dir returns to 0 and lk_in to 0.
- RX_SHIFT:
  - out_s is shifted in on the last clk cycle of each high phase.
  - After bit0's low phase: rx_data is updated, rx_valid=1, then go to IDLE.
- Byte latency: CLK_DIV + 16*CLK_DIV cycles from start. With CLK_DIV=4 this is 68 cycles.
  - TX: counted from IDLE exit to return to IDLE.
  - RX: counted to rx_valid rising.
- rx_valid clears on the cycle after rx_valid&rx_ready.
  - A new RX may start in that same cycle's IDLE evaluation, since rx_valid is then 0 at the register.
- cts_s or rts_s dropping mid-byte is ignored; the byte always completes.
- busy=1 in every state except IDLE.

Decomposition:
- w6link_pkg holds:
  - state enum (IDLE, TURN, TX_SHIFT, RX_SHIFT)
  - BYTE_W=8
  - DIR_H2D=1'b1, DIR_D2H=1'b0
- Sub-module w6link_sync: parameterised N-flop synchronizer with async reset, instantiated once per async input. It is shared with the device end.

Test Plan:
- Reset + idle: hold rst 3 cycles, cts/rts=0 → all outputs at reset values, lk_clk flat for 200 cycles, tx_ready=1.
- TX 0xA5, CLK_DIV=4, cts=1 → lk_dir=1, then 8 rising edges on lk_clk; lk_in at the rises reads 1,0,1,0,0,1,0,1; back to IDLE 68 cycles after start; tx_ready=1.
- TX blocked: cts=0, tx_valid with 0x3C → accepted (tx_ready=0), no lk_clk edges; raise cts → transfer starts within SYNC_STAGES+1 cycles.
- RX 0x5A: device model asserts rts and drives bits on lk_clk falling edges → rx_valid=1, rx_data=0x5A; with rx_ready=0, a second rts produces no lk_clk activity until the consumer takes the byte.
- Contention: tx pending 0x11, cts=1 and rts=1 simultaneously → RX performed first (lk_dir=0), then TX 0x11 with lk_dir=1.
- Reset mid-TX after 3 bits → lk_clk=0 and lk_dir=0 immediately, tx_ready=1; a following 0xFF TX is clean.

Source files
------------

// File: rtl/w6link_pkg.sv
// Shared types and constants for both ends of the w6 debug link.
// Pure declarations; no logic.
package w6link_pkg;
  typedef enum logic [1:0] {
    IDLE,
    TURN,
    TX_SHIFT,
    RX_SHIFT
  } state_e;

  localparam int   BYTE_W  = 8;
  localparam logic DIR_H2D = 1'b1;
  localparam logic DIR_D2H = 1'b0;
endpackage

// File: rtl/w6link_sync.sv
// N-flop synchronizer for one asynchronous link input, N cycles of latency.
// Shared by the host and device ends; no backpressure.
module w6link_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] ff_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= '0;
    else       ff_q <= (ff_q << 1) | N'(d_i);
  end

  assign q_o = ff_q[N-1];
endmodule

// File: rtl/w6link_host.sv
// Host end of the w6 link: one byte per 17*CLK_DIV cycles in either direction,
// RX preferred over TX, and an unconsumed rx byte blocks further RX starts.
module w6link_host
  import w6link_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              lk_clk,
  output logic              lk_dir,
  input  logic              lk_cts,
  input  logic              lk_rts,
  output logic              lk_in,
  input  logic              lk_out
);
  localparam int CNT_W = $clog2(CLK_DIV);

  logic cts_s, rts_s, out_s;

  w6link_sync #(.N(SYNC_STAGES)) u_sync_cts (.clk_i(clk), .rst_i(rst), .d_i(lk_cts), .q_o(cts_s));
  w6link_sync #(.N(SYNC_STAGES)) u_sync_rts (.clk_i(clk), .rst_i(rst), .d_i(lk_rts), .q_o(rts_s));
  w6link_sync #(.N(SYNC_STAGES)) u_sync_out (.clk_i(clk), .rst_i(rst), .d_i(lk_out), .q_o(out_s));

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              lk_clk_q, lk_clk_d;
  logic              dir_q, dir_d;
  logic              lk_in_q, lk_in_d;
  logic [BYTE_W-1:0] tx_hold_q, tx_hold_d;
  logic              tx_pend_q, tx_pend_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      lk_clk_q   <= 1'b0;
      dir_q      <= DIR_D2H;
      lk_in_q    <= 1'b0;
      tx_hold_q  <= '0;
      tx_pend_q  <= 1'b0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      lk_clk_q   <= lk_clk_d;
      dir_q      <= dir_d;
      lk_in_q    <= lk_in_d;
      tx_hold_q  <= tx_hold_d;
      tx_pend_q  <= tx_pend_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    lk_clk_d   = lk_clk_q;
    dir_d      = dir_q;
    lk_in_d    = lk_in_q;
    tx_hold_d  = tx_hold_q;
    tx_pend_d  = tx_pend_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    last       = (cnt_q == CNT_W'(CLK_DIV - 1));

    if (tx_valid && !tx_pend_q) begin
      tx_hold_d = tx_data;
      tx_pend_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Draining the device takes priority; a held rx byte blocks RX entirely.
        if (rts_s && !rx_valid_q) begin
          dir_d   = DIR_D2H;
          state_d = TURN;
        end else if (tx_pend_q && cts_s) begin
          dir_d   = DIR_H2D;
          lk_in_d = tx_hold_q[BYTE_W-1];
          state_d = TURN;
        end
      end
      TURN: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d    = '0;
          bit_d    = 3'd7;
          lk_clk_d = 1'b1;
          state_d  = (dir_q == DIR_H2D) ? TX_SHIFT : RX_SHIFT;
        end
      end
      TX_SHIFT, RX_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d = '0;
          if (lk_clk_q) begin
            lk_clk_d = 1'b0;
            if (state_q == RX_SHIFT)  shreg_d = {shreg_q[BYTE_W-2:0], out_s};
            else if (bit_q != 3'd0)   lk_in_d = tx_hold_q[bit_q - 3'd1];
          end else if (bit_q == 3'd0) begin
            state_d = IDLE;
            dir_d   = DIR_D2H;
            lk_in_d = 1'b0;
            if (state_q == TX_SHIFT) begin
              tx_pend_d = 1'b0;
            end else begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q - 3'd1;
            lk_clk_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready = !tx_pend_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
  assign lk_clk   = lk_clk_q;
  assign lk_dir   = dir_q;
  assign lk_in    = lk_in_q;
endmodule

// File: tb/tb_w6link_host.sv
// Bench for w6link_host: behavioural device model on the link pins.
// Expected byte latency CLK_DIV + 16*CLK_DIV cycles, derived from the parameters.
// Exercises CTS-blocked TX and rx_valid back-pressure on RX starts.
module tb_w6link_host;
    localparam int CLK_DIV = 4;
    localparam int SYNC    = 2;
    localparam int LAT     = CLK_DIV + 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy;
    logic       lk_clk, lk_dir, lk_in;
    logic       lk_cts = 1'b0;
    logic       lk_rts = 1'b0;
    logic       lk_out = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    w6link_host #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy),
        .lk_clk(lk_clk), .lk_dir(lk_dir), .lk_cts(lk_cts), .lk_rts(lk_rts),
        .lk_in(lk_in), .lk_out(lk_out)
    );

    logic rise_bits[$];
    logic rise_dirs[$];
    logic [7:0] dev_byte = '0;
    int dev_idx = 0;

    always @(posedge lk_clk) begin
        rise_bits.push_back(lk_in);
        rise_dirs.push_back(lk_dir);
    end

    always @(negedge lk_clk) begin
        if (lk_dir == 1'b0 && dev_idx > 0) begin
            dev_idx = dev_idx - 1;
            lk_out <= dev_byte[dev_idx];
        end
    end

    task automatic dev_load(input logic [7:0] b);
        dev_byte = b;
        dev_idx  = 7;
        lk_out   = b[7];
    endtask

    task automatic clear_caps();
        rise_bits.delete();
        rise_dirs.delete();
    endtask

    task automatic test_reset();
        int edges;
        rst = 1'b1; lk_cts = 1'b0; lk_rts = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({lk_clk, lk_dir, lk_in, rx_valid, busy} !== 5'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got clk/dir/in/rxv/busy=%b rx_data=%h, need 00000 and 00",
                     {lk_clk, lk_dir, lk_in, rx_valid, busy}, rx_data);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx_ready: got %b need 1", tx_ready);
        end
        clear_caps();
        edges = 0;
        repeat (200) begin
            @(negedge clk);
            if (lk_clk !== 1'b0) edges++;
        end
        checks++;
        if (edges != 0 || rise_bits.size() != 0) begin
            fails++;
            $display("FAIL idle_flat: lk_clk high %0d cycles, %0d rises, need 0", edges, rise_bits.size());
        end
    endtask

    task automatic test_tx_byte(input logic [7:0] b);
        int t;
        int n;
        int bad;
        lk_cts = 1'b1;
        clear_caps();
        @(negedge clk);
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL tx_accept: tx_ready=%b need 0", tx_ready);
        end
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b1 || lk_dir !== 1'b1) begin
            fails++;
            $display("FAIL tx_start: busy=%b lk_dir=%b need 1 1", busy, lk_dir);
        end
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n != LAT) begin
            fails++;
            $display("FAIL tx_latency: %0d cycles need %0d", n, LAT);
        end
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (rise_bits.size() != 8 || rise_bits[i] !== ((b >> (7 - i)) & 8'h1) || rise_dirs[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL tx_bits %h: %0d rises, %0d wrong bit/dir positions, need 8 and 0", b, rise_bits.size(), bad);
        end
        checks++;
        if (tx_ready !== 1'b1 || lk_dir !== 1'b0 || lk_in !== 1'b0) begin
            fails++;
            $display("FAIL tx_end: tx_ready=%b lk_dir=%b lk_in=%b need 1 0 0", tx_ready, lk_dir, lk_in);
        end
    endtask

    task automatic test_tx_blocked();
        int t;
        logic [7:0] got;
        lk_cts = 1'b0;
        repeat (4) @(negedge clk);
        clear_caps();
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b0 || rise_bits.size() != 0) begin
            fails++;
            $display("FAIL tx_blocked: tx_ready=%b busy=%b rises=%0d need 0 0 0", tx_ready, busy, rise_bits.size());
        end
        lk_cts = 1'b1;
        t = 0;
        while (!busy && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b1 || t > SYNC + 1) begin
            fails++;
            $display("FAIL tx_unblock: started after %0d cycles need <= %0d", t, SYNC + 1);
        end
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        got = '0;
        foreach (rise_bits[i]) got = {got[6:0], rise_bits[i]};
        checks++;
        if (rise_bits.size() != 8 || got !== 8'h3C) begin
            fails++;
            $display("FAIL tx_blocked_data: got %h in %0d rises need 3c in 8", got, rise_bits.size());
        end
    endtask

    task automatic test_rx_byte(input logic [7:0] b);
        int t;
        int n;
        int dbad;
        rx_ready = 1'b0;
        clear_caps();
        dev_load(b);
        lk_rts = 1'b1;
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        lk_rts = 1'b0;
        checks++;
        if (busy !== 1'b1 || lk_dir !== 1'b0) begin
            fails++;
            $display("FAIL rx_start: busy=%b lk_dir=%b need 1 0", busy, lk_dir);
        end
        n = 0;
        while (!rx_valid && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n != LAT) begin
            fails++;
            $display("FAIL rx_latency: %0d cycles need %0d", n, LAT);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== b) begin
            fails++;
            $display("FAIL rx_data: rx_valid=%b rx_data=%h need 1 %h", rx_valid, rx_data, b);
        end
        dbad = 0;
        foreach (rise_dirs[i]) if (rise_dirs[i] !== 1'b0) dbad++;
        checks++;
        if (rise_dirs.size() != 8 || dbad != 0) begin
            fails++;
            $display("FAIL rx_dir: %0d rises with %0d dir errors need 8 and 0", rise_dirs.size(), dbad);
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_consume: rx_valid=%b need 0", rx_valid);
        end
    endtask

    task automatic test_rx_backpressure();
        int t;
        test_rx_byte(8'h5A);
        clear_caps();
        dev_load(8'hC3);
        lk_rts = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rise_bits.size() != 0 || rx_data !== 8'h5A) begin
            fails++;
            $display("FAIL rx_backpressure: busy=%b rises=%0d rx_data=%h need 0 0 5a", busy, rise_bits.size(), rx_data);
        end
        consume();
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        lk_rts = 1'b0;
        t = 0;
        while (!rx_valid && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            fails++;
            $display("FAIL rx_second: rx_valid=%b rx_data=%h need 1 c3", rx_valid, rx_data);
        end
        consume();
    endtask

    task automatic test_contention();
        int t;
        logic [7:0] got;
        lk_cts = 1'b0;
        repeat (4) @(negedge clk);
        tx_data = 8'h11; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        clear_caps();
        dev_load(8'hE7);
        lk_cts = 1'b1; lk_rts = 1'b1;
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        lk_rts = 1'b0;
        checks++;
        if (busy !== 1'b1 || lk_dir !== 1'b0) begin
            fails++;
            $display("FAIL contention_first: busy=%b lk_dir=%b need 1 0", busy, lk_dir);
        end
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hE7) begin
            fails++;
            $display("FAIL contention_rx: rx_valid=%b rx_data=%h need 1 e7", rx_valid, rx_data);
        end
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (busy !== 1'b1 || lk_dir !== 1'b1) begin
            fails++;
            $display("FAIL contention_second: busy=%b lk_dir=%b need 1 1", busy, lk_dir);
        end
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        got = '0;
        for (int i = 8; i < 16; i++) if (i < rise_bits.size()) got = {got[6:0], rise_bits[i]};
        checks++;
        if (rise_bits.size() != 16 || got !== 8'h11 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL contention_tx: got %h in %0d rises tx_ready=%b need 11 in 16, 1", got, rise_bits.size(), tx_ready);
        end
        consume();
    endtask

    task automatic test_reset_mid_tx();
        int t;
        lk_cts = 1'b1;
        clear_caps();
        tx_data = 8'h96; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        t = 0;
        while (rise_bits.size() < 3 && t < 500) begin @(negedge clk); t++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lk_clk !== 1'b0 || lk_dir !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: clk=%b dir=%b tx_ready=%b busy=%b need 0 0 1 0", lk_clk, lk_dir, tx_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_tx_byte(8'hFF);
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                test_tx_byte(b);
            end else begin
                test_rx_byte(b);
                consume();
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx_byte(8'hA5);
        test_tx_blocked();
        test_rx_backpressure();
        test_contention();
        test_reset_mid_tx();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
